rc5_core: RTL and testbench
===========================

RC5_CORE -- requirements
Module: rc5_core

Interface
REQ-001 SHALL have parameter W, default 32: word width, legal values 16, 32 or 64.
REQ-002 SHALL have parameter R, default 12: round count, legal range 1..255.
REQ-003 SHALL have derived constants T=2*(R+1), T_LENGTH=$clog2(T) and ROT_VALUE=$clog2(W).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset on a single clock (rst=0 resets at a clk edge).
REQ-006 SHALL have port iValid  input  1  input block valid.
REQ-007 SHALL have port oReady  output  1  engine idle, block accepted when iValid&oReady.
REQ-008 SHALL have port iMode  input  1  0 = encipher, 1 = decipher; sampled at accept.
REQ-009 SHALL have ports iA, iB  input  W each  input words.
REQ-010 SHALL have ports oS_address1, oS_address2  output  T_LENGTH each  S-table read addresses (registered).
REQ-011 SHALL have ports iS_sub_i1, iS_sub_i2  input  W each  S[oS_address1], S[oS_address2]; valid one cycle after an address change, held while the address is stable.
REQ-012 SHALL have ports oA, oB  output  W each  result words.
REQ-013 SHALL have port oValid  output  1  result valid, held until consumed.
REQ-014 SHALL have port iReady  input  1  result consumed when oValid&iReady.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, PRE, HALF_A, HALF_B, POST, DONE.
REQ-016 SHALL drive oReady=1 only in IDLE; iValid in any other state is ignored.
REQ-017 On accept, SHALL latch iA, iB and iMode, and SHALL set round counter i=1 (encipher) or i=R (decipher).
REQ-018 On accept, SHALL set addresses to 0,1 (encipher) or 2R,2R+1 (decipher).
REQ-019 Encipher path SHALL be IDLE->FETCH->PRE (A+=S1i1, B+=S1i2, addr<=2,3).
REQ-020 Encipher SHALL then run {FETCH->HALF_A->HALF_B} per round: HALF_A A=((A^B)<<<B)+S[2i]; HALF_B B=((B^A)<<<A)+S[2i+1], i++, addr<=2i,2i+1.
REQ-021 Encipher SHALL go HALF_B->DONE when i==R.
REQ-022 Decipher per round SHALL run {FETCH->HALF_B->HALF_A}: HALF_B B=((B-S[2i+1])>>>A)^A; HALF_A A=((A-S[2i])>>>B)^B, i--, addr<=2i,2i+1.
REQ-023 Decipher SHALL go HALF_A->FETCH->POST (A-=S[0], B-=S[1])->DONE when i reaches 1.
REQ-024 Rotate amount SHALL be the low ROT_VALUE bits of the controlling word; an amount of 0 is identity; all add/subtract is modulo 2^W.
REQ-025 With accept at cycle 0, DONE (oValid=1) SHALL be first asserted at cycle 3R+3 for both modes.
REQ-026 In DONE, oA/oB SHALL be stable; on oValid&iReady the engine SHALL go to IDLE, with oReady=1 the next cycle.
REQ-027 With iReady held low, the engine SHALL stay in DONE indefinitely with no output change.
REQ-028 iMode/iA/iB changes after accept SHALL have no effect on the block in flight.
REQ-029 Out-of-range W or R SHALL cause an elaboration error.

Reset
REQ-030 While rst=0 at a clk edge: state=IDLE, oValid=0, oA=oB=0, addresses=0, counter=0.
REQ-031 oReady SHALL be 1 in the first cycle after rst returns high.
REQ-032 Reset mid-operation SHALL abort the block with no oValid pulse.

Structure
REQ-033 Package rc5_pkg SHALL hold the FSM state encoding, the legal-W check function, and the P/Q magic constants for W=16/32/64 (shared with key expansion).
REQ-034 SHALL instantiate exactly one combinational sub-module rc5_rotator (params W; ports iData, iRotate, iDir, oData), shared by both half-rounds and both modes.

Verification
REQ-035 W=32, R=12, S from all-zero 16-byte key, encipher A=0,B=0 -> oA=0xEEDBA521, oB=0x6D8F4B15, oValid first at cycle 39.
REQ-036 Same S, decipher A=0xEEDBA521, B=0x6D8F4B15 -> oA=0, oB=0, oValid at cycle 39.
REQ-037 Random A/B/S, W in {16,32,64}, R in {1,12,20}: encipher then decipher -> original words returned; address sequence matches the model each cycle.
REQ-038 iReady low 10 cycles in DONE plus iValid toggling -> oA/oB stable, oReady=0, no second accept; then iReady=1 -> IDLE next cycle.
REQ-039 rst=0 at cycle 7 of a block -> all outputs at reset values next cycle, no oValid, and the next block is correct.
REQ-040 A=B=0 with S chosen so all rotate amounts are 0 or W-1 -> results match the model (identity and maximum-rotate corners).

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: engine FSM encoding, parameter legality checks
// and the P/Q magic constants also used by the key-expansion logic.
package rc5_pkg;

  // Block-engine sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    PRE    = 3'd2,
    HALF_A = 3'd3,
    HALF_B = 3'd4,
    POST   = 3'd5,
    DONE   = 3'd6
  } rc5_state_e;

  // Magic constants P = Odd((e-2)*2^W), Q = Odd((phi-1)*2^W)
  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
  localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

  // Only the three standard RC5 word sizes are supported
  function automatic bit rc5_w_legal(input int w);
    return (w == 16) || (w == 32) || (w == 64);
  endfunction

  // Round count must fit the 8-bit round counter and be non-zero
  function automatic bit rc5_r_legal(input int r);
    return (r >= 1) && (r <= 255);
  endfunction

endpackage

// File: rtl/rc5_rotator.sv
// Combinational data-dependent rotator shared by all half-rounds.
// iDir=0 rotates left, iDir=1 rotates right; amount 0 passes data through.
module rc5_rotator #(
  parameter int W = 32
) (
  input  logic [W-1:0]         iData,
  input  logic [$clog2(W)-1:0] iRotate,
  input  logic                 iDir,
  output logic [W-1:0]         oData
);

  logic [2*W-1:0] dbl_word;
  logic [2*W-1:0] shl_word;
  logic [2*W-1:0] shr_word;

  // Shift a doubled copy of the word so the wrapped bits fall into place
  always_comb begin
    dbl_word = {iData, iData};
    shl_word = dbl_word << iRotate;
    shr_word = dbl_word >> iRotate;
    oData    = iDir ? shr_word[W-1:0] : shl_word[2*W-1:W];
  end

endmodule

// File: rtl/rc5_core.sv
// RC5 block cipher engine: one half-round per cycle, S-table held in an
// external synchronous-read memory addressed by this core.
module rc5_core
  import rc5_pkg::*;
#(
  parameter int W = 32,
  parameter int R = 12,
  localparam int T         = 2 * (R + 1),
  localparam int T_LENGTH  = $clog2(T),
  localparam int ROT_VALUE = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iValid,
  output logic                oReady,
  input  logic                iMode,
  input  logic [W-1:0]        iA,
  input  logic [W-1:0]        iB,
  output logic [T_LENGTH-1:0] oS_address1,
  output logic [T_LENGTH-1:0] oS_address2,
  input  logic [W-1:0]        iS_sub_i1,
  input  logic [W-1:0]        iS_sub_i2,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  output logic                oValid,
  input  logic                iReady
);

  generate
    if (!rc5_w_legal(W) || !rc5_r_legal(R)) begin : g_param_check
      $error("rc5_core: unsupported parameters W=%0d R=%0d", W, R);
    end
  endgenerate

  localparam logic [7:0] R_IDX = 8'(R);

  rc5_state_e          state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                mode_q, mode_d;
  logic [7:0]          i_q, i_d;
  logic [T_LENGTH-1:0] addr1_q, addr1_d;
  logic [T_LENGTH-1:0] addr2_q, addr2_d;

  logic [W-1:0]         rot_data;
  logic [ROT_VALUE-1:0] rot_amt;
  logic                 rot_dir;
  logic [W-1:0]         rot_out;

  rc5_rotator #(.W(W)) u_rotator (
    .iData   (rot_data),
    .iRotate (rot_amt),
    .iDir    (rot_dir),
    .oData   (rot_out)
  );

  // Select rotator operands for the half-round being executed this cycle
  always_comb begin
    rot_data = a_q ^ b_q;
    rot_amt  = b_q[ROT_VALUE-1:0];
    rot_dir  = 1'b0;
    case (state_q)
      HALF_A: begin
        rot_amt = b_q[ROT_VALUE-1:0];
        if (mode_q) begin
          rot_data = a_q - iS_sub_i1;
          rot_dir  = 1'b1;
        end else begin
          rot_data = a_q ^ b_q;
        end
      end
      HALF_B: begin
        rot_amt = a_q[ROT_VALUE-1:0];
        if (mode_q) begin
          rot_data = b_q - iS_sub_i2;
          rot_dir  = 1'b1;
        end else begin
          rot_data = b_q ^ a_q;
        end
      end
      default: ;
    endcase
  end

  // Next-state, datapath and S-table address sequencing
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    i_d     = i_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          a_d     = iA;
          b_d     = iB;
          mode_d  = iMode;
          state_d = FETCH;
          if (iMode) begin
            i_d     = R_IDX;
            addr1_d = T_LENGTH'({R_IDX, 1'b0});
            addr2_d = T_LENGTH'({R_IDX, 1'b1});
          end else begin
            i_d     = 8'd1;
            addr1_d = '0;
            addr2_d = T_LENGTH'(1);
          end
        end
      end
      // Wait for the S words at the new addresses; address 0 marks the
      // pre-whitening (encipher) or post-whitening (decipher) step
      FETCH: begin
        if (addr1_q == '0) begin
          state_d = mode_q ? POST : PRE;
        end else begin
          state_d = mode_q ? HALF_B : HALF_A;
        end
      end
      PRE: begin
        a_d     = a_q + iS_sub_i1;
        b_d     = b_q + iS_sub_i2;
        addr1_d = T_LENGTH'({i_q, 1'b0});
        addr2_d = T_LENGTH'({i_q, 1'b1});
        state_d = FETCH;
      end
      HALF_A: begin
        if (mode_q) begin
          a_d     = rot_out ^ b_q;
          i_d     = i_q - 8'd1;
          addr1_d = T_LENGTH'({i_q - 8'd1, 1'b0});
          addr2_d = T_LENGTH'({i_q - 8'd1, 1'b1});
          state_d = FETCH;
        end else begin
          a_d     = rot_out + iS_sub_i1;
          state_d = HALF_B;
        end
      end
      HALF_B: begin
        if (mode_q) begin
          b_d     = rot_out ^ a_q;
          state_d = HALF_A;
        end else begin
          b_d = rot_out + iS_sub_i2;
          if (i_q == R_IDX) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + 8'd1;
            addr1_d = T_LENGTH'({i_q + 8'd1, 1'b0});
            addr2_d = T_LENGTH'({i_q + 8'd1, 1'b1});
            state_d = FETCH;
          end
        end
      end
      POST: begin
        a_d     = a_q - iS_sub_i1;
        b_d     = b_q - iS_sub_i2;
        state_d = DONE;
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      i_q     <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
    end
  end

  assign oReady      = (state_q == IDLE);
  assign oValid      = (state_q == DONE);
  assign oA          = a_q;
  assign oB          = b_q;
  assign oS_address1 = addr1_q;
  assign oS_address2 = addr2_q;

endmodule

// File: tb/tb_rc5_core.sv
// Self-checking bench for rc5_core (W=32, R=12) with a result scoreboard.
module tb_rc5_core;

  localparam int W   = 32;
  localparam int R   = 12;
  localparam int T   = 2 * (R + 1);
  localparam int TL  = $clog2(T);
  localparam int LAT = 3 * R + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          iValid = 1'b0;
  logic          iMode = 1'b0;
  logic          iReady = 1'b0;
  logic [W-1:0]  iA = '0;
  logic [W-1:0]  iB = '0;
  logic [W-1:0]  s1 = '0;
  logic [W-1:0]  s2 = '0;
  logic [W-1:0]  oA, oB;
  logic [TL-1:0] addr1, addr2;
  logic          oReady, oValid;

  logic [W-1:0]   s_mem [T];
  logic [2*W-1:0] sb_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Synchronous-read S-table
  always @(posedge clk) begin
    s1 <= s_mem[addr1];
    s2 <= s_mem[addr2];
  end

  rc5_core #(.W(W), .R(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .iValid      (iValid),
    .oReady      (oReady),
    .iMode       (iMode),
    .iA          (iA),
    .iB          (iB),
    .oS_address1 (addr1),
    .oS_address2 (addr2),
    .iS_sub_i1   (s1),
    .iS_sub_i2   (s2),
    .oA          (oA),
    .oB          (oB),
    .oValid      (oValid),
    .iReady      (iReady)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  task automatic model_enc(input logic [31:0] a_in, b_in, output logic [31:0] a, b);
    a = a_in + s_mem[0];
    b = b_in + s_mem[1];
    for (int r = 1; r <= R; r++) begin
      a = rotl(a ^ b, int'(b[4:0])) + s_mem[2*r];
      b = rotl(b ^ a, int'(a[4:0])) + s_mem[2*r+1];
    end
  endtask

  task automatic model_dec(input logic [31:0] a_in, b_in, output logic [31:0] a, b);
    a = a_in;
    b = b_in;
    for (int r = R; r >= 1; r--) begin
      b = rotr(b - s_mem[2*r+1], int'(a[4:0])) ^ a;
      a = rotr(a - s_mem[2*r], int'(b[4:0])) ^ b;
    end
    b = b - s_mem[1];
    a = a - s_mem[0];
  endtask

  // Standard RC5-32 key schedule for an all-zero 16-byte key
  task automatic key_expand_zero();
    logic [31:0] l [4];
    logic [31:0] ka, kb;
    int si, lj;
    for (int j = 0; j < 4; j++) l[j] = '0;
    s_mem[0] = 32'hB7E15163;
    for (int k = 1; k < T; k++) s_mem[k] = s_mem[k-1] + 32'h9E3779B9;
    ka = '0; kb = '0; si = 0; lj = 0;
    for (int k = 0; k < 3 * T; k++) begin
      s_mem[si] = rotl(s_mem[si] + ka + kb, 3);
      ka = s_mem[si];
      l[lj] = rotl(l[lj] + ka + kb, int'((ka + kb) & 32'd31));
      kb = l[lj];
      si = (si + 1) % T;
      lj = (lj + 1) % 4;
    end
  endtask

  // Address pair expected c cycles after the accepting edge
  function automatic logic [2*TL-1:0] exp_addr(input logic mode, input int c);
    int k;
    if (!mode) k = (c >= LAT) ? 2 * R : 2 * (c / 3);
    else       k = 2 * (R - (c - 1) / 3);
    return {TL'(k), TL'(k + 1)};
  endfunction

  // Offer a block, wait for acceptance and push the expected result
  task automatic offer(input logic mode, input logic [31:0] a, b, ea, eb);
    int n;
    @(negedge clk);
    iValid = 1'b1; iMode = mode; iA = a; iB = b;
    n = 0;
    while (!oReady && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", oReady, 1'b1);
    sb_q.push_back({ea, eb});
    @(negedge clk);
    iValid = 1'b0; iMode = ~mode; iA = ~a; iB = $urandom;
  endtask

  task automatic run_block(input logic mode, input logic [31:0] a, b, ea, eb, input int hold);
    int c;
    logic [31:0] la, lb;
    logic [63:0] exp;
    offer(mode, a, b, ea, eb);
    c = 1;
    while (!oValid && c < LAT + 10) begin
      chk($sformatf("addr_c%0d", c), {addr1, addr2}, exp_addr(mode, c));
      @(negedge clk);
      c++;
    end
    chk("latency", c, LAT);
    chk("done_addr", {addr1, addr2}, exp_addr(mode, c));
    la = oA; lb = oB;
    for (int h = 0; h < hold; h++) begin
      iValid = h[0];
      @(negedge clk);
      chk("hold_stable", {oValid, oReady, oA, oB}, {1'b1, 1'b0, la, lb});
    end
    iValid = 1'b0;
    iReady = 1'b1;
    exp = sb_q.pop_front();
    chk(mode ? "dec_result" : "enc_result", {oA, oB}, exp);
    @(negedge clk);
    iReady = 1'b0;
    chk("idle_after", {oReady, oValid}, 2'b10);
    $display("block mode=%0d in=%h_%h out=%h_%h latency=%0d", mode, a, b, la, lb, c);
  endtask

  initial begin
    logic [31:0] ea, eb, ra, rb;
    logic        stray;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {oReady, oValid, oA, oB, addr1, addr2}, {1'b1, 1'b0, 64'd0, {(2*TL){1'b0}}});
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", oReady, 1'b1);

    // Known-answer vector and its inverse, with a long stall in DONE
    key_expand_zero();
    run_block(1'b0, 32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15, 10);
    run_block(1'b1, 32'hEEDBA521, 32'h6D8F4B15, 32'h0, 32'h0, 0);

    // Random S tables and words: encipher then decipher back
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < T; k++) s_mem[k] = $urandom;
      ra = $urandom; rb = $urandom;
      model_enc(ra, rb, ea, eb);
      run_block(1'b0, ra, rb, ea, eb, n);
      run_block(1'b1, ea, eb, ra, rb, 0);
    end

    // Rotate-amount corners: all amounts 0, then all amounts W-1
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < T; k++) s_mem[k] = (n == 0) ? 32'd0 : 32'd31;
      model_enc(32'd0, 32'd0, ea, eb);
      run_block(1'b0, 32'd0, 32'd0, ea, eb, 1);
      model_dec(ea, eb, ra, rb);
      run_block(1'b1, ea, eb, ra, rb, 0);
    end

    // Reset in the middle of a block
    for (int k = 0; k < T; k++) s_mem[k] = $urandom;
    ra = $urandom; rb = $urandom;
    model_enc(ra, rb, ea, eb);
    offer(1'b0, ra, rb, ea, eb);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {oReady, oValid, oA, oB, addr1, addr2}, {1'b1, 1'b0, 64'd0, {(2*TL){1'b0}}});
    void'(sb_q.pop_back());
    rst = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      stray = stray | oValid;
    end
    chk("midrst_no_valid", stray, 1'b0);
    $display("reset mid-block: no result produced");
    run_block(1'b0, ra, rb, ea, eb, 0);
    run_block(1'b1, ea, eb, ra, rb, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
